// File: rtl/row_clear_engine.sv
// row_clear_engine: removes one completed row from the board.
// The board is latched into a shadow copy. Every row above the cleared row
// moves down by one row, one row per cycle, and row 0 is then zeroed. The
// result is written back to the board owner with a one-cycle board_we strobe.
// While a clear is in progress, scan_pause holds the row scanner.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   game_pause     - blocks acceptance of a new clear
//   fallen_pieces  - current board; row r is bits [r*BLOCKS_WIDE +: BLOCKS_WIDE]
//   full_row       - row index presented by the row scanner
//   full_row_en    - full_row is completely filled
//   scan_pause     - freezes the row scanner during a clear
//   board_out      - updated board, valid while board_we is high (zero otherwise)
//   board_we       - one-cycle write strobe for board_out
//   lines_cleared  - saturating count of cleared rows
//   clear_done     - one-cycle pulse, coincident with board_we
module row_clear_engine #(
    parameter int unsigned BLOCKS_WIDE = 10,
    parameter int unsigned BLOCKS_HIGH = 22,
    parameter int unsigned BITS_Y_POS  = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               game_pause,
    input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] fallen_pieces,
    input  logic [BITS_Y_POS-1:0]              full_row,
    input  logic                               full_row_en,
    output logic                               scan_pause,
    output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_out,
    output logic                               board_we,
    output logic [15:0]                        lines_cleared,
    output logic                               clear_done
);

    localparam int unsigned BOARD_BITS = BLOCKS_WIDE * BLOCKS_HIGH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t                                 r_state;
    logic [BITS_Y_POS-1:0]                  r_cursor;
    logic [BLOCKS_HIGH-1:0][BLOCKS_WIDE-1:0] r_shadow;
    logic                                   r_scan_pause;
    logic [BOARD_BITS-1:0]                  r_board_out;
    logic                                   r_board_we;
    logic                                   r_clear_done;
    logic [15:0]                            r_lines_cleared;

    logic w_req_ok;

    // A request is only valid for a row that exists on the board
    assign w_req_ok = full_row_en && !game_pause && (32'(full_row) < BLOCKS_HIGH);

    // Clear sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_cursor        <= '0;
            r_shadow        <= '0;
            r_scan_pause    <= 1'b0;
            r_board_out     <= '0;
            r_board_we      <= 1'b0;
            r_clear_done    <= 1'b0;
            r_lines_cleared <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_ok) begin
                        r_shadow     <= fallen_pieces;
                        r_cursor     <= full_row;
                        r_scan_pause <= 1'b1;
                        r_state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cursor != '0) begin
                        r_shadow[r_cursor] <= r_shadow[r_cursor - BITS_Y_POS'(1)];
                        r_cursor           <= r_cursor - BITS_Y_POS'(1);
                    end else begin
                        // Row 0 is emptied in the shadow and in the write-back
                        // image, so the strobe is high for the whole COMMIT cycle
                        r_shadow[0]  <= '0;
                        r_board_out  <= {r_shadow[BLOCKS_HIGH-1:1], BLOCKS_WIDE'(0)};
                        r_board_we   <= 1'b1;
                        r_clear_done <= 1'b1;
                        r_state      <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_board_out  <= '0;
                    r_board_we   <= 1'b0;
                    r_clear_done <= 1'b0;
                    if (r_lines_cleared != 16'hFFFF) begin
                        r_lines_cleared <= r_lines_cleared + 16'd1;
                    end
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    // One extra paused cycle lets the scanner see the committed board
                    r_scan_pause <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign scan_pause    = r_scan_pause;
    assign board_out     = r_board_out;
    assign board_we      = r_board_we;
    assign clear_done    = r_clear_done;
    assign lines_cleared = r_lines_cleared;

endmodule

// File: tb/tb_row_clear_engine.sv
// Testbench for row_clear_engine. Directed scenarios and random clears are
// checked against a row-level reference model of the clear operation.
module tb_row_clear_engine;

    localparam int unsigned W  = 10;
    localparam int unsigned H  = 22;
    localparam int unsigned YB = 5;
    localparam int unsigned BB = W * H;

    logic          clk;
    logic          rst_n;
    logic          game_pause;
    logic [BB-1:0] fallen_pieces;
    logic [YB-1:0] full_row;
    logic          full_row_en;
    logic          scan_pause;
    logic [BB-1:0] board_out;
    logic          board_we;
    logic [15:0]   lines_cleared;
    logic          clear_done;

    int            n_checks;
    int            n_errors;
    logic [15:0]   exp_lines;
    logic [BB-1:0] last_result;

    row_clear_engine #(
        .BLOCKS_WIDE(W),
        .BLOCKS_HIGH(H),
        .BITS_Y_POS (YB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .game_pause   (game_pause),
        .fallen_pieces(fallen_pieces),
        .full_row     (full_row),
        .full_row_en  (full_row_en),
        .scan_pause   (scan_pause),
        .board_out    (board_out),
        .board_we     (board_we),
        .lines_cleared(lines_cleared),
        .clear_done   (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clearing row k: rows 1..k take the row above them, row 0 becomes empty,
    // rows below k are untouched.
    function automatic logic [BB-1:0] clear_model(input logic [BB-1:0] b, input int k);
        logic [BB-1:0] r;
        r = b;
        for (int row = 0; row <= k; row++) begin
            if (row == 0) r[0 +: W] = '0;
            else          r[row*W +: W] = b[(row-1)*W +: W];
        end
        return r;
    endfunction

    function automatic logic [BB-1:0] rand_board();
        logic [BB-1:0] b;
        for (int i = 0; i < int'(BB); i++) b[i] = 1'($urandom_range(0, 1));
        return b;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // mode 0: request held steady; 1: random input noise during the clear;
    // 2: game_pause raised right after acceptance
    task automatic run_clear(input string tag, input logic [BB-1:0] board, input int k, input int mode);
        logic [BB-1:0] exp_board;
        logic [BB-1:0] got;
        int n_high, we_cnt, we_at, bad_side;
        bit first, done;
        exp_board = clear_model(board, k);
        got = '0; n_high = 0; we_cnt = 0; we_at = 0; bad_side = 0; first = 0; done = 0;
        fallen_pieces = board;
        full_row      = YB'(k);
        full_row_en   = 1'b1;
        game_pause    = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            tick();
            if (c == 1) first = scan_pause;
            if (scan_pause === 1'b1) n_high++;
            else done = 1;
            if (board_we === 1'b1) begin
                we_cnt++;
                we_at = c;
                got = board_out;
            end else if (board_out !== '0) begin
                bad_side++;
            end
            if (clear_done !== board_we) bad_side++;
            if (!done) begin
                if (mode == 1) begin
                    fallen_pieces = rand_board();
                    full_row      = YB'($urandom_range(0, 31));
                    full_row_en   = 1'($urandom_range(0, 1));
                    game_pause    = 1'($urandom_range(0, 1));
                end else if (mode == 2) begin
                    game_pause    = 1'b1;
                    fallen_pieces = '0;
                end
            end else if (mode != 0) begin
                full_row_en = 1'b0;
                game_pause  = 1'b0;
            end
        end
        exp_lines = sat_inc(exp_lines);
        last_result = exp_board;
        check({tag, " accepted"},   BB'(first),    BB'(1));
        check({tag, " completed"},  BB'(done),     BB'(1));
        check({tag, " pause_len"},  BB'(n_high),   BB'(k + 3));
        check({tag, " we_count"},   BB'(we_cnt),   BB'(1));
        check({tag, " we_cycle"},   BB'(we_at),    BB'(k + 2));
        check({tag, " board_out"},  got,           exp_board);
        check({tag, " idle_outs"},  BB'(bad_side), BB'(0));
        check({tag, " lines"},      BB'(lines_cleared), BB'(exp_lines));
    endtask

    // Request that must be refused: nothing may move for a few cycles
    task automatic expect_ignored(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            check({tag, " scan_pause"}, BB'(scan_pause), BB'(0));
            check({tag, " board_we"},   BB'(board_we),   BB'(0));
        end
        check({tag, " lines"}, BB'(lines_cleared), BB'(exp_lines));
    endtask

    initial begin
        logic [BB-1:0] chk;
        logic [BB-1:0] b2;
        n_checks = 0; n_errors = 0; exp_lines = '0; last_result = '0;
        rst_n = 1'b0; game_pause = 1'b0; fallen_pieces = '0; full_row = '0; full_row_en = 1'b0;
        #1;
        check("reset scan_pause", BB'(scan_pause), BB'(0));
        check("reset board_we",   BB'(board_we),   BB'(0));
        check("reset clear_done", BB'(clear_done), BB'(0));
        check("reset board_out",  board_out,       '0);
        check("reset lines",      BB'(lines_cleared), BB'(0));
        tick(); tick();
        rst_n = 1'b1;

        // Paused game refuses a valid request
        fallen_pieces = rand_board(); full_row = YB'(5); full_row_en = 1'b1; game_pause = 1'b1;
        expect_ignored("game_pause", 4);
        full_row_en = 1'b0; game_pause = 1'b0;

        // Out-of-range row index is refused
        full_row = YB'(25); full_row_en = 1'b1;
        expect_ignored("row25", 4);
        full_row_en = 1'b0;

        // Row 21 full over a checker pattern
        chk = '0;
        for (int r = 0; r < int'(H) - 1; r++) chk[r*W +: W] = (r % 2 == 0) ? 10'h2AA : 10'h155;
        chk[(H-1)*W +: W] = '1;
        run_clear("row21", chk, 21, 1);
        tick();

        // Row 0 clear
        run_clear("row0", rand_board(), 0, 1);
        tick();

        // game_pause raised after acceptance does not stop the clear
        run_clear("pause_mid", rand_board(), 7, 2);
        tick();

        // Reset during the shift of row 10
        fallen_pieces = rand_board(); full_row = YB'(10); full_row_en = 1'b1;
        tick(); tick(); tick(); tick();
        check("pre_reset busy", BB'(scan_pause), BB'(1));
        rst_n = 1'b0;
        #1;
        check("abort scan_pause", BB'(scan_pause), BB'(0));
        check("abort board_we",   BB'(board_we),   BB'(0));
        check("abort board_out",  board_out,       '0);
        check("abort lines",      BB'(lines_cleared), BB'(0));
        exp_lines = '0;
        tick();
        check("abort held board_we", BB'(board_we), BB'(0));
        rst_n = 1'b1;

        // Accepted on the first edge after release, then back-to-back row 21
        b2 = rand_board();
        b2[(H-1)*W +: W] = '1;
        run_clear("b2b_first", b2, 21, 0);
        b2 = last_result;
        b2[(H-1)*W +: W] = '1;
        run_clear("b2b_second", b2, 21, 0);
        full_row_en = 1'b0;
        tick();

        // Random clears with input noise
        for (int i = 0; i < 8; i++) begin
            run_clear("random", rand_board(), int'($urandom_range(0, H - 1)), 1);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Counter saturation
        force dut.r_lines_cleared = 16'hFFFF;
        tick();
        release dut.r_lines_cleared;
        exp_lines = 16'hFFFF;
        tick();
        check("sat preset", BB'(lines_cleared), BB'(16'hFFFF));
        run_clear("saturate", rand_board(), 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/row_clear_engine.md
ROW_CLEAR_ENGINE -- requirements
Module: row_clear_engine

Interface
REQ-001 Parameter BLOCKS_WIDE, default 10: cells per board row.
REQ-002 Parameter BLOCKS_HIGH, default 22: rows per board; row 0 is the top row.
REQ-003 Parameter BITS_Y_POS, default 5: width of a row index.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 game_pause  input  1: when high, no new clear is accepted.
REQ-007 fallen_pieces  input  BLOCKS_WIDE*BLOCKS_HIGH: current board; row r occupies bits [r*BLOCKS_WIDE +: BLOCKS_WIDE].
REQ-008 full_row  input  BITS_Y_POS: row index presented by the row scanner.
REQ-009 full_row_en  input  1: high when full_row is completely filled.
REQ-010 scan_pause  output  1: freezes the row scanner while a clear is in progress.
REQ-011 board_out  output  BLOCKS_WIDE*BLOCKS_HIGH: updated board, valid while board_we is high.
REQ-012 board_we  output  1: one-cycle strobe; the board owner loads board_out on this edge.
REQ-013 lines_cleared  output  16: running count of cleared rows.
REQ-014 clear_done  output  1: one-cycle pulse, coincident with board_we.

Function
REQ-015 The block SHALL implement the states IDLE, SHIFT, COMMIT and SETTLE.
REQ-016 In IDLE, with full_row_en=1, game_pause=0 and full_row<BLOCKS_HIGH, the block SHALL:
  - latch shadow<=fallen_pieces and cursor<=full_row;
  - set scan_pause<=1;
  - enter SHIFT.
REQ-017 In IDLE, a request with full_row>=BLOCKS_HIGH SHALL be ignored and the block SHALL stay in IDLE.
REQ-018 In SHIFT with cursor>0, the block SHALL copy shadow row cursor-1 into shadow row cursor and decrement cursor, one row per cycle.
REQ-019 In SHIFT with cursor==0, the block SHALL clear shadow row 0 to all zeros and enter COMMIT.
REQ-020 Cycle budget: a clear of row k SHALL spend exactly k+1 cycles in SHIFT.
REQ-021 In COMMIT, for exactly one cycle, the block SHALL:
  - drive board_out=shadow, board_we=1 and clear_done=1;
  - increment lines_cleared, saturating at 16'hFFFF;
  - enter SETTLE.
REQ-022 In SETTLE, the block SHALL hold scan_pause=1 for one cycle so the scanner sees the committed board, then set scan_pause<=0 and return to IDLE.
REQ-023 For a row-k request, scan_pause SHALL be high for exactly k+3 consecutive cycles.
REQ-024 Once a clear has been accepted, it SHALL complete regardless of game_pause, full_row_en or fallen_pieces changes.
REQ-025 While not in IDLE, the block SHALL ignore full_row and full_row_en.
REQ-026 Outside COMMIT, board_we and clear_done SHALL be 0; board_out SHALL be all zeros.
REQ-027 Rows below the cleared row (index >k) SHALL be bit-identical in board_out and in the latched board.
REQ-028 In IDLE, a new request SHALL be accepted no earlier than the cycle after SETTLE.

Reset
REQ-029 With rst_n=0, the block SHALL immediately (asynchronously) force:
  - state=IDLE, cursor=0, shadow=0;
  - scan_pause=0, board_we=0, clear_done=0;
  - board_out=0, lines_cleared=0.
REQ-030 Reset asserted mid-clear SHALL abort the clear with no board_we pulse and no count increment.
REQ-031 After rst_n rises, the block SHALL accept a request from the first clock edge.

Verification
REQ-032 Bench directed scenarios:
  - Row 21 full, rows 0..20 a checker pattern; request row 21 -> 22 cycles in SHIFT, board_we pulse; board_out rows 1..21 = old rows 0..20, row 0 = 0; lines_cleared=1; scan_pause high 24 cycles.
  - Request row 0 -> SHIFT 1 cycle; board_out = input with row 0 zeroed; scan_pause high 3 cycles.
  - game_pause=1 with full_row_en=1 -> no state change, scan_pause=0, no board_we; then game_pause raised mid-clear -> clear still commits.
  - rst_n pulsed low during SHIFT of row 10 -> all outputs 0 at once, no board_we; next request after release is accepted.
  - Two back-to-back requests (rows 21 then 21 again after reload) -> lines_cleared=2; the second is accepted only after SETTLE.
  - full_row=25 with full_row_en=1 -> ignored; lines_cleared with preset 16'hFFFF stays 16'hFFFF after a clear.
